shift_lane_arbiter: RTL and testbench
=====================================

# shift_lane_arbiter

Round-robin controller that shares one serial shift lane between two parallel-word requesters. It accepts a WIDTH-bit word from the granted requester via valid/ready and loads it into an internal shift register. It then shifts the word out MSB-first, one bit per cycle, with framing strobes, and enforces a programmable idle gap between frames. It sits in front of the downstream serial datapath, the bit-serial consumer whose input is a single `in` bit sampled on `clk`.

## Interface
- WIDTH, 4: bits per word; legal range WIDTH >= 2.
- GAP, 1: idle cycles inserted after each frame's last bit; legal range GAP >= 0.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in0_data  input  WIDTH  word from requester 0.
- in0_valid  input  1  requester 0 has a word.
- in0_ready  output  1  requester 0 word accepted this cycle (when in0_valid also high).
- in1_data  input  WIDTH  word from requester 1.
- in1_valid  input  1  requester 1 has a word.
- in1_ready  output  1  requester 1 word accepted this cycle (when in1_valid also high).
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a frame bit.
- ser_first  output  1  ser_out is bit WIDTH-1 of the frame (first bit).
- ser_last  output  1  ser_out is bit 0 of the frame (last bit).
- grant_id  output  1  requester that owns the current or most recent frame.
- busy  output  1  high in SHIFT and GAP.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: WIDTH cycles, one per bit.
  - GAP: GAP cycles; skipped entirely when GAP == 0.
- Round-robin pointer `prio`:
  - Names the requester that wins a tie.
  - After each accepted word, prio becomes the other requester.
- Arbitration, in IDLE only:
  - Only one valid high: that requester is granted.
  - Both valid: requester `prio` is granted.
- Ready outputs:
  - inX_ready = (state == IDLE) && (requester X granted).
  - Ready is combinational from the valids and prio.
  - At most one ready is high in any cycle; both are low outside IDLE.
- Handshake:
  - Occurs when inX_valid && inX_ready.
  - On the handshake edge: shift register <= inX_data, grant_id <= X, bit counter <= 0, state <= SHIFT.
- SHIFT:
  - Combinational outputs: ser_out = sr[WIDTH-1], ser_valid = 1, ser_first = (cnt == 0), ser_last = (cnt == WIDTH-1).
  - Each edge: sr <= {sr[WIDTH-2:0], 1'b0} and cnt <= cnt + 1.
  - On the ser_last edge: state <= GAP (gap counter <= 0) if GAP > 0, else state <= IDLE.
- GAP:
  - ser_valid, ser_first, ser_last and ser_out are all 0.
  - Gap counter increments each cycle; after GAP cycles, state <= IDLE.
- Outside SHIFT: ser_out, ser_valid, ser_first and ser_last are 0.
- Counter widths:
  - cnt is max(1, $clog2(WIDTH)) bits.
  - Gap counter is max(1, $clog2(GAP+1)) bits.
  - Neither counter wraps mid-frame.
- Data path:
  - inX_data is sampled only on the handshake edge.
  - Input changes at any other time have no effect on the frame in flight.
- Requester behaviour:
  - A requester holding valid high across a frame is served in the next IDLE cycle by round-robin.
  - Valid may drop without a handshake; no state is affected.
- Reset:
  - state = IDLE, sr = 0, cnt = 0, gap counter = 0, prio = 0, grant_id = 0.
  - busy and all ser_* outputs are 0.
  - Reset takes priority over a handshake in the same cycle.
  - rst asserted mid-frame aborts the frame: ser_valid is 0 from the cycle after the reset edge, and no remaining bits are emitted.

## Timing
- Handshake at edge t:
  - First bit (ser_first) visible in cycle t+1.
  - Last bit (ser_last) visible in cycle t+WIDTH.
  - GAP cycles follow: t+WIDTH+1 .. t+WIDTH+GAP.
  - IDLE in cycle t+WIDTH+GAP+1; a new handshake is possible in that same cycle.
- Frame period: WIDTH+GAP+1 cycles minimum; 6 cycles at the default parameters.
- busy is high in cycles t+1 .. t+WIDTH+GAP; low in IDLE.
- ready is low from cycle t+1 until the state returns to IDLE.
- grant_id changes only on a handshake edge or on reset.

## Test plan
- Reset then idle: hold rst 2 cycles with both valids low. Required: readys 0, ser_valid 0, busy 0, grant_id 0 for 10 cycles.
- Single word: in0_data = 4'b1011, in0_valid for one accepted cycle. Required:
  - ser_out = 1, 0, 1, 1 on the next 4 cycles; ser_first on bit 1, ser_last on bit 4.
  - 1 GAP cycle, then in0_ready back high.
- Contention: both valid continuously, in0_data = 4'hA, in1_data = 4'h5. Required:
  - Grants alternate 0, 1, 0, 1; serial stream 1010, 0101, 1010, 0101.
  - Exactly 6 cycles between successive ser_first pulses.
- Input stability: change in0_data to 4'hF mid-frame after accepting 4'h3. Required: frame bits stay 0011.
- Mid-frame reset: assert rst on the 2nd bit of a frame. Required:
  - ser_valid 0 from the next cycle; no ser_last seen.
  - After rst is released, the first grant goes to requester 0 when both are valid.
- GAP = 0 build: back-to-back requests on requester 1. Required: ser_first pulses every WIDTH+1 = 5 cycles, with zero GAP cycles between frames.

Source files
------------

// File: rtl/shift_lane_arbiter.sv
// shift_lane_arbiter: round-robin owner of one serial shift lane shared by two
// parallel-word requesters. A granted word is shifted out MSB-first with
// first/last strobes, followed by a fixed idle gap before the next grant.
module shift_lane_arbiter #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             grant_id,
    output logic             busy
);
    localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             prio_q, prio_d;
    logic             grant_q, grant_d;
    logic             idle, shifting, req_any, win;

    // Arbitration: a tie goes to prio, otherwise the sole requester wins.
    always_comb begin
        idle      = (state_q == S_IDLE);
        shifting  = (state_q == S_SHIFT);
        req_any   = in0_valid | in1_valid;
        win       = (in0_valid && in1_valid) ? prio_q : in1_valid;
        in0_ready = idle && in0_valid && !win;
        in1_ready = idle && in1_valid && win;
    end

    // Next-state logic: load on handshake, shift WIDTH bits, then idle gap.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    sr_d    = win ? in1_data : in0_data;
                    grant_d = win;
                    prio_d  = !win;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gcnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gcnt_d = gcnt_q + 1'b1;
                if (gcnt_q == GAP_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset wins over a same-cycle handshake and aborts a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
        end
    end

    // Serial strobes are only live while shifting.
    always_comb begin
        ser_out   = shifting && sr_q[WIDTH-1];
        ser_valid = shifting;
        ser_first = shifting && (cnt_q == '0);
        ser_last  = shifting && (cnt_q == CNT_LAST);
        grant_id  = grant_q;
        busy      = !idle;
    end
endmodule

// File: tb/tb_shift_lane_arbiter.sv
// Bench for shift_lane_arbiter: a GAP=1 and a GAP=0 instance share stimulus
// and are each checked every cycle against a timeline model of the lane.
module tb_shift_lane_arbiter;
    localparam int W = 4;

    logic         clk, rst, v0, v1;
    logic [W-1:0] d0, d1;

    logic a_r0, a_r1, a_so, a_sv, a_sf, a_sl, a_gid, a_busy;
    logic b_r0, b_r1, b_so, b_sv, b_sf, b_sl, b_gid, b_busy;
    logic [7:0] obs [2];

    shift_lane_arbiter #(.WIDTH(W), .GAP(1)) dut_a (
        .clk(clk), .rst(rst),
        .in0_data(d0), .in0_valid(v0), .in0_ready(a_r0),
        .in1_data(d1), .in1_valid(v1), .in1_ready(a_r1),
        .ser_out(a_so), .ser_valid(a_sv), .ser_first(a_sf), .ser_last(a_sl),
        .grant_id(a_gid), .busy(a_busy)
    );

    shift_lane_arbiter #(.WIDTH(W), .GAP(0)) dut_b (
        .clk(clk), .rst(rst),
        .in0_data(d0), .in0_valid(v0), .in0_ready(b_r0),
        .in1_data(d1), .in1_valid(v1), .in1_ready(b_r1),
        .ser_out(b_so), .ser_valid(b_sv), .ser_first(b_sf), .ser_last(b_sl),
        .grant_id(b_gid), .busy(b_busy)
    );

    // Field order: in0_ready in1_ready ser_out ser_valid ser_first ser_last grant_id busy
    assign obs[0] = {a_r0, a_r1, a_so, a_sv, a_sf, a_sl, a_gid, a_busy};
    assign obs[1] = {b_r0, b_r1, b_so, b_sv, b_sf, b_sl, b_gid, b_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a frame is "word w handshaken in cycle ths"; everything else is
    // derived from the cycle distance to that handshake.
    typedef struct {
        bit           hf;
        int           ths;
        logic [W-1:0] w;
        bit           prio;
        bit           gid;
    } mdl_t;

    mdl_t m [2];
    int   gap_v [2];
    int   last_first [2];
    int   cyc;
    bit   chk_period;
    int   n_assert, n_fail;

    function automatic bit mdl_idle(input mdl_t s, input int gap, input int c);
        return !s.hf || (c > s.ths + W + gap);
    endfunction

    function automatic bit mdl_win(input mdl_t s, input bit iv0, input bit iv1);
        if (iv0 && iv1) return s.prio;
        return !iv0;
    endfunction

    function automatic logic [7:0] expect_of(input mdl_t s, input int gap, input int c,
                                             input bit iv0, input bit iv1);
        logic [7:0] e;
        bit idle, win;
        int k;
        idle = mdl_idle(s, gap, c);
        win  = mdl_win(s, iv0, iv1);
        k    = c - s.ths - 1;
        e    = '0;
        e[7] = idle && iv0 && !win;
        e[6] = idle && iv1 && win;
        if (s.hf && k >= 0 && k < W) begin
            e[5] = s.w[W-1-k];
            e[4] = 1'b1;
            e[3] = (k == 0);
            e[2] = (k == W - 1);
        end
        e[1] = s.gid;
        e[0] = !idle;
        return e;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].hf = 0; m[i].ths = 0; m[i].w = '0; m[i].prio = 0; m[i].gid = 0;
        end
    endtask

    // One cycle: drive, check mid-cycle, clock edge, advance model.
    task automatic step(input bit iv0, input logic [W-1:0] id0,
                        input bit iv1, input logic [W-1:0] id1, input bit irst);
        logic [7:0] e;
        bit win;
        v0 = iv0; d0 = id0; v1 = iv1; d1 = id1; rst = irst;
        #1;
        for (int i = 0; i < 2; i++) begin
            e = expect_of(m[i], gap_v[i], cyc, iv0, iv1);
            n_assert++;
            assert (obs[i] === e) else begin
                n_fail++;
                $error("FAIL outputs dut%0d cyc=%0d observed=%b expected=%b (r0 r1 so sv sf sl gid busy)",
                       i, cyc, obs[i], e);
            end
            if (chk_period && obs[i][3] === 1'b1) begin
                if (last_first[i] >= 0) begin
                    n_assert++;
                    assert (cyc - last_first[i] == W + gap_v[i] + 1) else begin
                        n_fail++;
                        $error("FAIL first_spacing dut%0d cyc=%0d observed=%0d expected=%0d",
                               i, cyc, cyc - last_first[i], W + gap_v[i] + 1);
                    end
                end
                last_first[i] = cyc;
            end
        end
        @(posedge clk);
        if (irst) mdl_reset();
        else begin
            for (int i = 0; i < 2; i++) begin
                if (mdl_idle(m[i], gap_v[i], cyc) && (iv0 || iv1)) begin
                    win       = mdl_win(m[i], iv0, iv1);
                    m[i].hf   = 1;
                    m[i].ths  = cyc;
                    m[i].w    = win ? id1 : id0;
                    m[i].gid  = win;
                    m[i].prio = !win;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic period_on();
        chk_period = 1;
        last_first[0] = -1;
        last_first[1] = -1;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; chk_period = 0;
        gap_v[0] = 1; gap_v[1] = 0;
        last_first[0] = -1; last_first[1] = -1;
        mdl_reset();
        rst = 1'b1; v0 = 0; v1 = 0; d0 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state held with no requests.
        repeat (10) step(0, 4'h0, 0, 4'h0, 0);

        // Single word 1011 from requester 0, then a second request after the gap.
        step(1, 4'b1011, 0, 4'h0, 0);
        repeat (5) step(0, 4'h0, 0, 4'h0, 0);
        step(1, 4'h6, 0, 4'h0, 0);
        repeat (6) step(0, 4'h0, 0, 4'h0, 0);

        // Contention from a fresh prio: grants alternate at minimum period.
        step(0, 4'h0, 0, 4'h0, 1);
        period_on();
        repeat (26) step(1, 4'hA, 1, 4'h5, 0);
        chk_period = 0;
        repeat (7) step(0, 4'h0, 0, 4'h0, 0);

        // Input stability: data changes after the handshake are ignored.
        step(1, 4'h3, 0, 4'h0, 0);
        repeat (6) step(0, 4'hF, 0, 4'h0, 0);

        // Mid-frame reset on the 2nd bit, then both request.
        step(1, 4'h9, 0, 4'h0, 0);
        step(0, 4'h0, 0, 4'h0, 0);
        step(0, 4'h0, 0, 4'h0, 1);
        repeat (12) step(1, 4'hC, 1, 4'h2, 0);
        repeat (7) step(0, 4'h0, 0, 4'h0, 0);

        // Back-to-back requests on requester 1.
        period_on();
        for (int n = 0; n < 20; n++) step(0, 4'h0, 1, W'($urandom), 0);
        chk_period = 0;

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++)
            step(1'($urandom), W'($urandom), 1'($urandom), W'($urandom),
                 $urandom_range(0, 39) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
